// File: rtl/ps_pwm_pkg.sv
// Shared types and default constants for the phase-shifted PWM engine.
`timescale 1ns/1ps
package ps_pwm_pkg;

    localparam int PS_PWM_WIDTH = 6;
    localparam int PS_PWM_N_CH  = 2;
    localparam int PS_PWM_DT_W  = 5;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        DEAD_H = 3'd1,
        ON_H   = 3'd2,
        DEAD_L = 3'd3,
        ON_L   = 3'd4
    } dt_state_t;

endpackage

// File: rtl/ps_pwm_multich_deadtime.sv
// deadtime_gen: one complementary gate pair with dead-time insertion.
// Gates are registered from the next-state value, so they never glitch.
`timescale 1ns/1ps
module deadtime_gen
    import ps_pwm_pkg::*;
#(
    parameter int DT_W = PS_PWM_DT_W
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            PWM_IN,
    input  logic [DT_W-1:0] DT,
    output logic            GATE_H,
    output logic            GATE_L
);

    dt_state_t       state_q, state_d;
    dt_state_t       enter_state;
    logic [DT_W-1:0] timer_q, timer_d;
    logic [DT_W-1:0] enter_timer;
    logic            gate_h_q, gate_h_d;
    logic            gate_l_q, gate_l_d;
    logic            dt_zero;

    // Every (re)entry heads toward the current PWM level; zero dead time skips DEAD_x.
    always_comb begin
        dt_zero     = (DT == '0);
        enter_timer = dt_zero ? '0 : DT - DT_W'(1);
        if (PWM_IN) begin
            enter_state = dt_zero ? ON_H : DEAD_H;
        end else begin
            enter_state = dt_zero ? ON_L : DEAD_L;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!EN) begin
            state_d = OFF;
            timer_d = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = enter_state;
                    timer_d = enter_timer;
                end
                DEAD_H: begin
                    if (!PWM_IN) begin
                        state_d = enter_state;
                        timer_d = enter_timer;
                    end else if (timer_q == '0) begin
                        state_d = ON_H;
                    end else begin
                        timer_d = timer_q - DT_W'(1);
                    end
                end
                ON_H: begin
                    if (!PWM_IN) begin
                        state_d = enter_state;
                        timer_d = enter_timer;
                    end
                end
                DEAD_L: begin
                    if (PWM_IN) begin
                        state_d = enter_state;
                        timer_d = enter_timer;
                    end else if (timer_q == '0) begin
                        state_d = ON_L;
                    end else begin
                        timer_d = timer_q - DT_W'(1);
                    end
                end
                ON_L: begin
                    if (PWM_IN) begin
                        state_d = enter_state;
                        timer_d = enter_timer;
                    end
                end
                default: begin
                    state_d = OFF;
                    timer_d = '0;
                end
            endcase
        end
        gate_h_d = (state_d == ON_H);
        gate_l_d = (state_d == ON_L);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= OFF;
            timer_q  <= '0;
            gate_h_q <= 1'b0;
            gate_l_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            gate_h_q <= gate_h_d;
            gate_l_q <= gate_l_d;
        end
    end

    assign GATE_H = gate_h_q;
    assign GATE_L = gate_l_q;

endmodule

// File: rtl/ps_pwm_multich.sv
// Phase-shifted multi-channel PWM: shared carrier, per-channel shadow duty, dead-time legs.
// Optional SYNC output (one pulse per carrier wrap) enabled by defining PS_PWM_SYNC_OUT_EN.
`timescale 1ns/1ps
module ps_pwm_multich
    import ps_pwm_pkg::*;
#(
    parameter int WIDTH = PS_PWM_WIDTH,
    parameter int N_CH  = PS_PWM_N_CH,
    parameter int DT_W  = PS_PWM_DT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [N_CH*WIDTH-1:0] DUTY,
    input  logic [DT_W-1:0]       DT,
    output logic [N_CH-1:0]       GATE_H,
    output logic [N_CH-1:0]       GATE_L
`ifdef PS_PWM_SYNC_OUT_EN
    ,
    output logic                  SYNC
`endif
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam int unsigned      PH_STEP = (2 ** WIDTH) / N_CH;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cnt_k [N_CH];
    logic [WIDTH-1:0] duty_act_q [N_CH];
    logic [WIDTH-1:0] duty_act_d [N_CH];
    logic [DT_W-1:0]  dt_act_q, dt_act_d;
    logic [N_CH-1:0]  pwm_q, pwm_d;

    always_comb begin
        cnt_d      = EN ? cnt_q + WIDTH'(1) : '0;
        dt_act_d   = (!EN || cnt_q == CNT_MAX) ? DT : dt_act_q;
        duty_act_d = duty_act_q;
        pwm_d      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cnt_k[k] = cnt_q + WIDTH'(k * PH_STEP);
            // Shadow load only at this channel's own wrap so a period is never split.
            if (!EN || cnt_k[k] == CNT_MAX) begin
                duty_act_d[k] = DUTY[k*WIDTH +: WIDTH];
            end
            pwm_d[k] = (cnt_k[k] < duty_act_q[k]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            dt_act_q   <= '0;
            pwm_q      <= '0;
            duty_act_q <= '{default: '0};
        end else begin
            cnt_q      <= cnt_d;
            dt_act_q   <= dt_act_d;
            pwm_q      <= pwm_d;
            duty_act_q <= duty_act_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        deadtime_gen #(
            .DT_W(DT_W)
        ) u_dt (
            .CLK   (CLK),
            .RST   (RST),
            .EN    (EN),
            .PWM_IN(pwm_q[k]),
            .DT    (dt_act_q),
            .GATE_H(GATE_H[k]),
            .GATE_L(GATE_L[k])
        );
    end

`ifdef PS_PWM_SYNC_OUT_EN
    logic sync_q, sync_d;

    always_comb begin
        sync_d = EN && (cnt_q == CNT_MAX);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign SYNC = sync_q;
`endif

endmodule

// File: tb/tb_ps_pwm_multich.sv
// Self-checking bench for ps_pwm_multich: window-rule gate model plus directed literal checks.
`timescale 1ns/1ps
module tb_ps_pwm_multich;

    localparam int W    = 6;
    localparam int NCH  = 2;
    localparam int DTW  = 5;
    localparam int PER  = 64;
    localparam int OFFS = PER / NCH;

    logic             clk  = 1'b0;
    logic             rst  = 1'b0;
    logic             en   = 1'b0;
    logic [NCH*W-1:0] duty = '0;
    logic [DTW-1:0]   dt   = '0;
    logic [NCH-1:0]   gate_h, gate_l;
`ifdef PS_PWM_SYNC_OUT_EN
    logic             sync;
`endif

    int nerr = 0;
    int nchk = 0;
    bit done = 1'b0;

    ps_pwm_multich #(
        .WIDTH(W),
        .N_CH (NCH),
        .DT_W (DTW)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .EN    (en),
        .DUTY  (duty),
        .DT    (dt),
        .GATE_H(gate_h),
        .GATE_L(gate_l)
`ifdef PS_PWM_SYNC_OUT_EN
        ,
        .SYNC  (sync)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a gate is on at cycle t+1 iff EN was high and pwm sat at its level for
    // the last dt+1 cycles ending at t; reset/EN-low clears that history.
    int        m_cnt, m_dt;
    int        m_duty [NCH];
    bit        m_pwm  [NCH];
    bit        m_new  [NCH];
    bit [32:0] hist_h [NCH];
    bit [32:0] hist_l [NCH];
    bit        exp_h  [NCH];
    bit        exp_l  [NCH];
    bit        m_sync;
    int        ck;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  = 0;
            m_dt   = 0;
            m_sync = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                m_duty[k] = 0;
                m_pwm[k]  = 1'b0;
                hist_h[k] = '0;
                hist_l[k] = '0;
                exp_h[k]  = 1'b0;
                exp_l[k]  = 1'b0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                hist_h[k] = {hist_h[k][31:0], (en &&  m_pwm[k])};
                hist_l[k] = {hist_l[k][31:0], (en && !m_pwm[k])};
                exp_h[k]  = 1'b1;
                exp_l[k]  = 1'b1;
                for (int j = 0; j <= m_dt; j++) begin
                    exp_h[k] = exp_h[k] & hist_h[k][j];
                    exp_l[k] = exp_l[k] & hist_l[k][j];
                end
            end
            m_sync = en && (m_cnt == PER - 1);
            for (int k = 0; k < NCH; k++) begin
                ck       = (m_cnt + k * OFFS) % PER;
                m_new[k] = (ck < m_duty[k]);
                if (!en || ck == PER - 1) m_duty[k] = int'(duty[k*W +: W]);
            end
            if (!en || m_cnt == PER - 1) m_dt = int'(dt);
            m_pwm = m_new;
            m_cnt = en ? (m_cnt + 1) % PER : 0;
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("gate_h[%0d]", k), int'(gate_h[k]), int'(exp_h[k]));
                check($sformatf("gate_l[%0d]", k), int'(gate_l[k]), int'(exp_l[k]));
                check($sformatf("overlap[%0d]", k), int'(gate_h[k] & gate_l[k]), 0);
            end
`ifdef PS_PWM_SYNC_OUT_EN
            check("sync", int'(sync), int'(m_sync));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_win(input int n, output int h0, output int h1, output int l0, output int l1);
        h0 = 0; h1 = 0; l0 = 0; l1 = 0;
        repeat (n) begin
            @(negedge clk);
            h0 += int'(gate_h[0]);
            h1 += int'(gate_h[1]);
            l0 += int'(gate_l[0]);
            l1 += int'(gate_l[1]);
        end
    endtask

    task automatic first_gate(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (gate_h[0] | gate_l[0]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_counts(input string nm, input int eh0, input int eh1, input int el0, input int el1);
        int h0, h1, l0, l1;
        count_win(PER, h0, h1, l0, l1);
        check({nm, "_h0"}, h0, eh0);
        check({nm, "_h1"}, h1, eh1);
        check({nm, "_l0"}, l0, el0);
        check({nm, "_l1"}, l1, el1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mism;
        bit found, ne;
        bit rh0 [96];
        bit rh1 [96];
        bit rl0 [96];
        bit rl1 [96];

        #1 rst = 1'b1;
        #11;
        check("reset_gate_h", int'(gate_h), 0);
        check("reset_gate_l", int'(gate_l), 0);
        #10 rst = 1'b0;

        // steady state, DUTY 28/28, DT 3
        step(1);
        duty = {6'd28, 6'd28};
        dt   = 5'd3;
        step(3);
        en = 1'b1;
        step(130);
        check_counts("d28", 25, 25, 33, 33);

        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            rh0[i] = gate_h[0]; rh1[i] = gate_h[1];
            rl0[i] = gate_l[0]; rl1[i] = gate_l[1];
        end
        mism = 0;
        for (int t = 0; t < 64; t++) begin
            if (rh1[t+OFFS] != rh0[t]) mism++;
            if (rl1[t+OFFS] != rl0[t]) mism++;
        end
        check("ch1_shift32", mism, 0);

        // mid-period duty change on ch0 at cnt = 10
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1);
            if (m_cnt == 10) found = 1'b1;
        end
        check("reach_cnt10", int'(found), 1);
        duty[5:0] = 6'd46;
        step(140);
        check_counts("d46", 43, 25, 15, 33);

        // duty 0: only GATE_L, after the dead time
        en   = 1'b0;
        duty = '0;
        step(4);
        en = 1'b1;
        first_gate(n);
        check("d0_first_gate_cycle", n, 5);
        check("d0_first_is_l", int'(gate_l[0]), 1);
        step(70);
        check_counts("d0", 0, 0, 64, 64);

        // duty 63: one-cycle low pulse is swallowed
        en   = 1'b0;
        duty = {6'd63, 6'd63};
        step(2);
        en = 1'b1;
        step(130);
        check_counts("d63", 60, 60, 0, 0);

        // duty 2: short high pulse is swallowed
        en   = 1'b0;
        duty = {6'd2, 6'd2};
        step(2);
        en = 1'b1;
        step(130);
        check_counts("d2", 0, 0, 59, 59);

        // EN dropped during ON_H, then reasserted
        en   = 1'b0;
        duty = {6'd28, 6'd28};
        step(2);
        en = 1'b1;
        step(70);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (!gate_h[0]) found = 1'b1;
        end
        check("wait_h0_low", int'(found), 1);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (gate_h[0]) found = 1'b1;
        end
        check("wait_h0_rise", int'(found), 1);
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1;
        check("en_drop_gate_h", int'(gate_h), 0);
        check("en_drop_gate_l", int'(gate_l), 0);
        step(5);
        en = 1'b1;
        first_gate(n);
        check("en_restart_first_cycle", n, 5);
        check("en_restart_first_is_h", int'(gate_h[0]), 1);

        // asynchronous reset mid-period
        step(40);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gate_h", int'(gate_h), 0);
        check("async_rst_gate_l", int'(gate_l), 0);
        en = 1'b0;
        step(2);
        @(negedge clk);
        #2 rst = 1'b0;
        step(3);
        en = 1'b1;
        first_gate(n);
        check("post_rst_first_cycle", n, 5);
        step(130);
        check_counts("post_rst", 25, 25, 33, 33);

        // zero dead time
        en = 1'b0;
        dt = '0;
        step(2);
        en = 1'b1;
        step(80);

        // random duty / EN / DT (DT only changes while EN is low)
        for (int s = 0; s < 25; s++) begin
            ne   = ($urandom_range(0, 4) != 0);
            duty = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
            if (!ne) dt = 5'($urandom_range(0, 10));
            en = ne;
            step($urandom_range(8, 90));
        end

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
